// File: rtl/panel_input_scanner_if.sv
// panel_input_scanner_if: panel pins, register-file strobes and scanner outputs.
interface panel_input_scanner_if #(
   parameter int N_BUT = 13,
   parameter int N_ENC = 2,
   parameter int CNT_W = 8
);
   logic [N_BUT-1:0] but_n, but_evt_clr, but_state, but_evt;
   logic [N_ENC-1:0] enc_a, enc_b, enc_zero, enc_evt_clr, enc_evt, enc_err;
   logic [N_ENC*CNT_W-1:0] enc_count, enc_snap;
   logic snap, any_pressed, irq;
   modport master (
      output but_n, enc_a, enc_b, snap, enc_zero, but_evt_clr, enc_evt_clr,
      input but_state, any_pressed, but_evt, enc_count, enc_snap, enc_evt, enc_err, irq
   );
   modport slave (
      input but_n, enc_a, enc_b, snap, enc_zero, but_evt_clr, enc_evt_clr,
      output but_state, any_pressed, but_evt, enc_count, enc_snap, enc_evt, enc_err, irq
   );
endinterface

// File: rtl/panel_input_scanner.sv
// panel_input_scanner: debounced buttons and filtered quadrature encoders with sticky events and irq.
// Define PANEL_ENC_X4_EN for x4 decode; the default build counts once per full cycle (x1).
module panel_input_scanner #(
   parameter int N_BUT = 13,
   parameter int N_ENC = 2,
   parameter int CNT_W = 8,
   parameter int ENC_FILT = 2,
   parameter int DB_DIV = 1000,
   parameter int DB_CNT = 8
) (
   input logic clk,
   input logic reset_n,
   panel_input_scanner_if.slave bus
);
   localparam int PW = $clog2(DB_DIV);
   localparam int DW = $clog2(DB_CNT + 1);
   localparam int FW = $clog2(ENC_FILT + 1);
   localparam int WW = $clog2(ENC_FILT + 3);
   localparam int NI = 2 * N_ENC;
   logic [N_BUT-1:0] but_s1, but_s2, but_st, but_ev, flip;
   logic [NI-1:0] enc_s1, enc_s2, enc_f;
   logic [FW-1:0] run [NI];
   logic [DW-1:0] db [N_BUT];
   logic [PW-1:0] pre;
   logic [WW-1:0] warm;
   logic [N_ENC-1:0] primed, chg, up, dn, ill, evt, err;
   logic [1:0] prev [N_ENC];
   logic [1:0] cur [N_ENC];
   logic [CNT_W-1:0] cnt [N_ENC];
   logic [CNT_W-1:0] snp [N_ENC];
   logic tick, prime, irq_r;
   // Quadrature position along the forward sequence 00->10->11->01 for {A,B}
   function automatic logic [1:0] pos(input logic [1:0] ab);
      return {ab[0], ab[1] ^ ab[0]};
   endfunction
   assign tick = pre == PW'(DB_DIV - 1);
   assign prime = warm == WW'(ENC_FILT + 2);
   always_comb begin
      flip = '0;
      chg = '0;
      up = '0;
      dn = '0;
      ill = '0;
      for (int i = 0; i < N_BUT; i++)
         flip[i] = tick && (!but_s2[i] != but_st[i]) && db[i] == DW'(DB_CNT - 1);
      for (int i = 0; i < N_ENC; i++) begin
         cur[i] = {enc_f[i], enc_f[N_ENC + i]};
         chg[i] = primed[i] && cur[i] != prev[i];
         ill[i] = chg[i] && (pos(cur[i]) - pos(prev[i])) == 2'd2;
`ifdef PANEL_ENC_X4_EN
         up[i] = chg[i] && (pos(cur[i]) - pos(prev[i])) == 2'd1;
         dn[i] = chg[i] && (pos(cur[i]) - pos(prev[i])) == 2'd3;
`else
         up[i] = chg[i] && (pos(cur[i]) - pos(prev[i])) == 2'd1 && cur[i] == 2'b00;
         dn[i] = chg[i] && (pos(cur[i]) - pos(prev[i])) == 2'd3 && prev[i] == 2'b00;
`endif
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         but_s1 <= '1;
         but_s2 <= '1;
         enc_s1 <= '0;
         enc_s2 <= '0;
         enc_f <= '0;
         pre <= '0;
         warm <= '0;
         primed <= '0;
         but_st <= '0;
         but_ev <= '0;
         evt <= '0;
         err <= '0;
         irq_r <= 1'b0;
         for (int i = 0; i < N_BUT; i++) db[i] <= '0;
         for (int i = 0; i < NI; i++) run[i] <= '0;
         for (int i = 0; i < N_ENC; i++) begin
            prev[i] <= '0;
            cnt[i] <= '0;
            snp[i] <= '0;
         end
      end else begin
         but_s1 <= bus.but_n;
         but_s2 <= but_s1;
         enc_s1 <= {bus.enc_b, bus.enc_a};
         enc_s2 <= enc_s1;
         pre <= tick ? '0 : pre + 1'b1;
         warm <= prime ? warm : warm + 1'b1;
         for (int i = 0; i < N_BUT; i++)
            if (tick) db[i] <= (!but_s2[i] == but_st[i] || flip[i]) ? '0 : db[i] + 1'b1;
         but_st <= but_st ^ flip;
         but_ev <= (but_ev & ~bus.but_evt_clr) | (flip & ~but_st);
         for (int i = 0; i < NI; i++)
            if (enc_s2[i] == enc_f[i]) run[i] <= '0;
            else if (run[i] == FW'(ENC_FILT - 1)) begin
               enc_f[i] <= enc_s2[i];
               run[i] <= '0;
            end else run[i] <= run[i] + 1'b1;
         // First sample after the filters settle becomes the reference without counting
         for (int i = 0; i < N_ENC; i++) begin
            if (prime && !primed[i]) begin
               prev[i] <= cur[i];
               primed[i] <= 1'b1;
            end else if (chg[i]) prev[i] <= cur[i];
            cnt[i] <= bus.enc_zero[i] ? '0 : up[i] ? cnt[i] + 1'b1 : dn[i] ? cnt[i] - 1'b1 : cnt[i];
            if (bus.snap) snp[i] <= cnt[i];
         end
         evt <= (evt & ~bus.enc_evt_clr) | ((up | dn) & ~bus.enc_zero);
         err <= (err & ~bus.enc_evt_clr) | ill;
         irq_r <= |but_ev || |evt;
      end
   assign bus.but_state = but_st;
   assign bus.any_pressed = |but_st;
   assign bus.but_evt = but_ev;
   assign bus.enc_evt = evt;
   assign bus.enc_err = err;
   assign bus.irq = irq_r;
   for (genvar c = 0; c < N_ENC; c++) begin : g_pack
      assign bus.enc_count[c*CNT_W +: CNT_W] = cnt[c];
      assign bus.enc_snap[c*CNT_W +: CNT_W] = snp[c];
   end
endmodule

// File: tb/tb_panel_input_scanner.sv
// tb_panel_input_scanner: directed stimulus with a queued-expectation scoreboard for panel_input_scanner.
module tb_panel_input_scanner;
   localparam int NB = 13, NE = 2, CW = 8, EF = 2, LAT = EF + 3;
`ifdef PANEL_ENC_X4_EN
   localparam bit X4 = 1'b1;
`else
   localparam bit X4 = 1'b0;
`endif
   typedef struct { string name; int sel; logic [31:0] exp; int due; } chk_t;
   typedef struct { logic [7:0] exp; int due; } cnt_t;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int cyc = 0, checks = 0, errors = 0, f1 = -1;
   chk_t gq[$];
   cnt_t cq[$];
   logic [7:0] model_cnt = 8'h00, last_cnt = 8'h00;
   logic last_bs5 = 1'b0;
   panel_input_scanner_if #(.N_BUT(NB), .N_ENC(NE), .CNT_W(CW)) bus();
   panel_input_scanner #(.N_BUT(NB), .N_ENC(NE), .CNT_W(CW), .ENC_FILT(EF), .DB_DIV(4), .DB_CNT(3))
      dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [31:0] act(int sel);
      case (sel)
         0: return 32'(bus.enc_count);
         1: return 32'(bus.enc_snap[7:0]);
         2: return 32'(bus.enc_err);
         3: return 32'(bus.enc_evt);
         4: return 32'(bus.irq);
         5: return 32'(bus.but_state);
         6: return 32'(bus.but_evt);
         7: return 32'(bus.any_pressed);
         8: return 32'(bus.enc_snap);
         9: return 32'(bus.enc_count[7:0]);
         default: return 32'(bus.enc_count[15:8]);
      endcase
   endfunction
   // Monitor: scheduled checks fire on their cycle; every ch0 count change consumes one expectation
   always @(negedge clk) begin
      cnt_t c;
      for (int i = gq.size() - 1; i >= 0; i--)
         if (gq[i].due == cyc) begin
            checks++;
            if (act(gq[i].sel) !== gq[i].exp) begin
               errors++;
               $display("FAIL %s: got %0h, expected %0h (cycle %0d)", gq[i].name, act(gq[i].sel), gq[i].exp, cyc);
            end
            gq.delete(i);
         end
      if (bus.enc_count[7:0] !== last_cnt) begin
         checks++;
         if (cq.size() == 0) begin
            errors++;
            $display("FAIL count_unexpected: got %0h, expected %0h (cycle %0d)", bus.enc_count[7:0], last_cnt, cyc);
         end else begin
            c = cq.pop_front();
            if (bus.enc_count[7:0] !== c.exp || cyc != c.due) begin
               errors++;
               $display("FAIL count_step: got %0h at cycle %0d, expected %0h at cycle %0d", bus.enc_count[7:0], cyc, c.exp, c.due);
            end
         end
         last_cnt = bus.enc_count[7:0];
      end else if (cq.size() != 0 && cq[0].due < cyc) begin
         checks++;
         errors++;
         c = cq.pop_front();
         $display("FAIL count_missing: got %0h, expected %0h by cycle %0d", bus.enc_count[7:0], c.exp, c.due);
      end
      if (bus.but_state[5] && !last_bs5 && f1 < 0) f1 = cyc;
      last_bs5 = bus.but_state[5];
   end
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(string n, int sel, logic [31:0] e, int dly);
      gq.push_back('{n, sel, e, cyc + dly});
   endtask
   task automatic expect_cnt(logic [7:0] e, int dly);
      cq.push_back('{e, cyc + dly});
      model_cnt = e;
   endtask
   task automatic enc_set(logic a, logic b, logic [7:0] e4, logic [7:0] e1);
      logic [7:0] e = X4 ? e4 : e1;
      bus.enc_a[0] = a;
      bus.enc_b[0] = b;
      if (e != model_cnt) expect_cnt(e, LAT);
   endtask
   task automatic enc_to(logic a, logic b, logic [7:0] e4, logic [7:0] e1);
      enc_set(a, b, e4, e1);
      step(6);
   endtask
   task automatic clr_flags();
      bus.enc_evt_clr = '1;
      bus.but_evt_clr = '1;
      step(1);
      bus.enc_evt_clr = '0;
      bus.but_evt_clr = '0;
      step(2);
   endtask
   task automatic zero_ch0();
      bus.enc_zero = 2'b01;
      expect_cnt(8'h00, 1);
      step(1);
      bus.enc_zero = '0;
      step(2);
   endtask
   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected finish by 300000");
      $fatal(1, "watchdog expired");
   end
   initial begin
      int k, n;
      bus.but_n = '1;
      bus.enc_a = '1;
      bus.enc_b = '1;
      bus.snap = 1'b0;
      bus.enc_zero = '0;
      bus.but_evt_clr = '0;
      bus.enc_evt_clr = '0;
      #1 reset_n = 1'b0;
      step(3);
      chk("rst_count", 0, 0, 0);
      chk("rst_irq", 4, 0, 0);
      chk("rst_but_state", 5, 0, 0);
      chk("rst_snap", 8, 0, 0);
      reset_n = 1'b1;
      step(20);
      chk("idle_count", 0, 0, 0);
      chk("idle_err", 2, 0, 0);
      chk("idle_evt", 3, 0, 0);
      chk("idle_irq", 4, 0, 0);
      chk("idle_but_state", 5, 0, 0);
      chk("idle_but_evt", 6, 0, 0);
      chk("idle_any", 7, 0, 0);
      step(1);
      enc_to(0, 1, 8'h01, 8'h00);
      enc_to(0, 0, 8'h02, 8'h01);
      zero_ch0();
      clr_flags();
      chk("clr_evt", 3, 0, 0);
      chk("clr_irq", 4, 0, 0);
      enc_to(1, 0, 8'h01, 8'h00);
      enc_to(1, 1, 8'h02, 8'h00);
      enc_to(0, 1, 8'h03, 8'h00);
      clr_flags();
      chk("pre_fwd_irq", 4, 0, 0);
      enc_set(0, 0, 8'h04, 8'h01);
      chk("fwd_evt", 3, 1, LAT);
      chk("fwd_irq_lag", 4, 0, LAT);
      chk("fwd_irq", 4, 1, LAT + 1);
      step(8);
      chk("fwd_count", 9, X4 ? 8'h04 : 8'h01, 0);
      enc_to(0, 1, 8'h03, 8'h00);
      enc_to(1, 1, 8'h02, 8'h00);
      enc_to(1, 0, 8'h01, 8'h00);
      enc_to(0, 0, 8'h00, 8'h00);
      enc_to(0, 1, 8'hFF, 8'hFF);
      chk("rev_count", 9, 8'hFF, 0);
      bus.enc_a[0] = 1'b1;
      step(1);
      bus.enc_a[0] = 1'b0;
      step(8);
      chk("glitch_count", 9, 8'hFF, 0);
      enc_to(0, 0, 8'h00, 8'h00);
      clr_flags();
      enc_set(1, 1, 8'h00, 8'h00);
      chk("ill_err", 2, 1, LAT);
      chk("ill_evt", 3, 0, LAT);
      chk("ill_count", 9, 0, LAT);
      step(7);
      bus.enc_evt_clr = 2'b01;
      step(1);
      bus.enc_evt_clr = '0;
      chk("err_clr", 2, 0, 0);
      step(2);
      enc_to(0, 1, 8'h01, 8'h00);
      enc_to(0, 0, 8'h02, 8'h01);
      zero_ch0();
      for (int i = 0; i < (X4 ? 4 : 16); i++) begin
         enc_to(1, 0, 8'(4 * i + 1), 8'(i));
         enc_to(1, 1, 8'(4 * i + 2), 8'(i));
         enc_to(0, 1, 8'(4 * i + 3), 8'(i));
         enc_to(0, 0, 8'(4 * i + 4), 8'(i + 1));
      end
      if (!X4) begin
         enc_to(1, 0, 8'h10, 8'h10);
         enc_to(1, 1, 8'h10, 8'h10);
         enc_to(0, 1, 8'h10, 8'h10);
      end
      if (X4) enc_set(1, 0, 8'h11, 8'h11);
      else enc_set(0, 0, 8'h11, 8'h11);
      step(4);
      bus.snap = 1'b1;
      step(1);
      bus.snap = 1'b0;
      chk("snap_pre", 1, 8'h10, 0);
      chk("snap_count", 9, 8'h11, 0);
      step(6);
      chk("snap_hold", 1, 8'h10, 0);
      clr_flags();
      if (X4) enc_set(1, 1, 8'h00, 8'h00);
      else enc_set(0, 1, 8'h00, 8'h00);
      step(4);
      bus.enc_zero = 2'b01;
      step(1);
      bus.enc_zero = '0;
      chk("zero_evt", 3, 0, 0);
      chk("zero_irq", 4, 0, 1);
      chk("zero_count", 9, 0, 1);
      step(6);
      bus.but_n[5] = 1'b0;
      step(6);
      bus.but_n[5] = 1'b1;
      step(6);
      bus.but_n[5] = 1'b0;
      step(5);
      bus.but_n[5] = 1'b1;
      step(8);
      chk("bounce_state", 5, 0, 0);
      chk("bounce_evt", 6, 0, 0);
      bus.but_n[5] = 1'b0;
      chk("db_early", 5, 0, 10);
      chk("db_state", 5, 32'h20, 15);
      chk("db_evt", 6, 32'h20, 15);
      chk("db_any", 7, 1, 15);
      chk("db_irq", 4, 1, 16);
      step(20);
      bus.but_n[5] = 1'b1;
      step(20);
      chk("rel_state", 5, 0, 0);
      chk("rel_evt", 6, 32'h20, 0);
      chk("rel_any", 7, 0, 0);
      bus.but_evt_clr[5] = 1'b1;
      step(1);
      bus.but_evt_clr[5] = 1'b0;
      chk("but_clr", 6, 0, 0);
      chk("but_clr_irq", 4, 0, 1);
      step(5);
      k = f1 < 0 ? 0 : f1;
      n = ((k - 3 - cyc) % 4 + 4) % 4;
      if (n > 0) step(n);
      bus.but_n[5] = 1'b0;
      step(10);
      bus.but_evt_clr[5] = 1'b1;
      step(1);
      bus.but_evt_clr[5] = 1'b0;
      chk("setclr_state", 5, 32'h20, 0);
      chk("setclr_evt", 6, 32'h20, 0);
      chk("setclr_evt_hold", 6, 32'h20, 2);
      step(4);
      bus.but_n[5] = 1'b1;
      step(20);
      chk("ch1_count", 10, 0, 0);
      step(3);
      foreach (gq[i]) begin
         checks++;
         errors++;
         $display("FAIL %s: got no check, expected one at cycle %0d", gq[i].name, gq[i].due);
      end
      foreach (cq[i]) begin
         checks++;
         errors++;
         $display("FAIL count_pending: got no change, expected %0h at cycle %0d", cq[i].exp, cq[i].due);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/panel_input_scanner.md
Name: panel_input_scanner

Overview:
- Parametrised front-panel input block: N_BUT debounced active-low buttons and N_ENC filtered quadrature encoders with CNT_W-bit wrapping counters.
- Adds sticky press/motion event flags, a single irq output, per-channel counter zeroing, illegal-transition detection and an atomic counter snapshot.
- Sits between the panel pins and the serial-bus IO register file, which reads its outputs and drives its strobes.

Parameters:
- N_BUT, 13, number of buttons.
- N_ENC, 2, number of quadrature encoders.
- CNT_W, 8, counter width per encoder.
- ENC_FILT, 2, consecutive clocks a synced encoder input must differ before it is accepted (≥1).
- DB_DIV, 1000, clocks per debounce sample tick (≥2).
- DB_CNT, 8, consecutive differing ticks before a button state flips (≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- but_n  in  N_BUT  raw buttons, 0 = pressed.
- enc_a  in  N_ENC  raw encoder A.
- enc_b  in  N_ENC  raw encoder B.
- snap  in  1  strobe: latch all counters into enc_snap.
- enc_zero  in  N_ENC  strobe: zero the selected counters.
- but_evt_clr  in  N_BUT  write-1-to-clear for but_evt.
- enc_evt_clr  in  N_ENC  write-1-to-clear for enc_evt and enc_err.
- but_state  out  N_BUT  debounced state, 1 = pressed.
- any_pressed  out  1  OR of but_state.
- but_evt  out  N_BUT  sticky released→pressed events.
- enc_count  out  N_ENC*CNT_W  live counters; channel i at [i*CNT_W +: CNT_W].
- enc_snap  out  N_ENC*CNT_W  snapshot registers, same packing.
- enc_evt  out  N_ENC  sticky: counter changed.
- enc_err  out  N_ENC  sticky: illegal double-bit transition seen.
- irq  out  1  registered OR of all but_evt and enc_evt bits.

Behaviour:
- Reset: every output 0; prescaler, debounce counters, filters and primed flags cleared; async assert, sync-release use is the caller's concern.
- Synchronisation: every raw input passes a 2-flop synchroniser.
- Buttons:
  - Prescaler pulses tick once per DB_DIV clocks.
  - On tick, per button: if the synced pressed value equals but_state, clear that button's counter; otherwise increment it, and when it reaches DB_CNT, flip but_state and clear the counter.
  - A 0→1 flip of but_state sets but_evt.
- Encoder filter, per input: the filtered value takes the synced value on the clock on which the synced value has differed from it for ENC_FILT consecutive clocks; any agreement resets the run.
  - Latency from a raw edge to the counter update is ENC_FILT+3 clocks.
- Priming: a primed flag per channel is cleared by reset. On the first clock after the filters have run ENC_FILT+2 clocks, the current {A,B} is loaded as previous state, the flag is set, and no count occurs.
- Decode (primed channels), on the clock after the filtered {A,B} changes:
  - Forward sequence 00→10→11→01→00: each step +1.
  - Reverse sequence: each step −1.
  - 00↔11 or 10↔01: no count, set enc_err.
  - Counter wraps modulo 2^CNT_W (0xFF+1 = 0x00; 0x00−1 = 0xFF).
  - Any count change sets enc_evt.
- Zeroing: enc_zero[i] sets counter i to 0 on the next clock. If a count step coincides, zero wins and enc_evt is not set.
- Snapshot: snap copies all counters at the same edge, using pre-update values if a step coincides. enc_snap holds until the next snap.
- Sticky flags: when a set and a clear coincide, set wins.
- irq is registered one clock after the flag registers.

Optional Feature:
- PANEL_ENC_X4_EN defined: x4 decode as above, every legal edge counts.
- Undefined: x1 decode; only 01→00 counts +1 and 00→01 counts −1. Other legal steps only update the previous state. Illegal-transition detection is unchanged.

Test Plan:
- Reset with enc_a=enc_b=1, release reset, hold inputs steady 20 clocks -> enc_count=0, enc_err=0, all outputs 0.
- X4: one full forward cycle starting at 00 -> count 4, enc_evt=1, irq=1 one clock later. Then 5 reverse edges -> count 0xFF. Each update lands exactly ENC_FILT+3 clocks after its edge.
- X1: same forward cycle -> count 1; reverse cycle -> count 0.
- Glitches and illegal steps:
  - A toggled for 1 clock (ENC_FILT=2) -> no change in filtered value or count.
  - 00→11 step -> enc_err=1, count unchanged.
  - enc_evt_clr -> enc_err=0.
- Debounce (DB_DIV=4, DB_CNT=3), button 5 pulled low:
  - Bouncing shorter than 3 ticks -> no change.
  - Stable low -> but_state[5]=1 after 3 ticks, but_evt[5]=1, any_pressed=1.
  - Release -> but_evt stays 1 until but_evt_clr[5].
  - Set and clear on the same clock -> but_evt stays 1.
- Count 0x10, assert snap and one forward step on the same clock -> enc_snap=0x10, enc_count=0x11. Then enc_zero with a coincident step -> count 0x00, enc_evt unchanged.
